// File: rtl/fetcher_icache.sv
// fetcher_icache: instruction fetch stage with a direct-mapped one-instruction-per-line cache.
//   clk, reset              : clock, synchronous active-high reset
//   core_state, current_pc  : core FSM state and address to fetch
//   invalidate              : one-cycle pulse clearing every valid bit
//   mem_read_*              : program memory valid/ready read handshake
//   fetcher_state           : IDLE=000 FETCHING=001 FETCHED=010
//   instruction             : registered instruction, stable while FETCHED
//   hit_count, miss_count   : saturating lookup statistics
module fetcher_icache #(
   parameter int PROGRAM_MEM_ADDR_BITS = 8,
   parameter int PROGRAM_MEM_DATA_BITS = 16,
   parameter int CACHE_LINES = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [2:0]                       core_state,
   input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
   input  logic                             invalidate,
   output logic                             mem_read_valid,
   output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
   input  logic                             mem_read_ready,
   input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
   output logic [2:0]                       fetcher_state,
   output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
   output logic [15:0]                      hit_count,
   output logic [15:0]                      miss_count
);
   localparam int IW = $clog2(CACHE_LINES);
   localparam int TW = PROGRAM_MEM_ADDR_BITS - IW;
   localparam logic [2:0] C_FETCH = 3'b001;
   localparam logic [2:0] C_DECODE = 3'b010;
   typedef enum logic [2:0] {S_IDLE = 3'b000, S_FETCHING = 3'b001, S_FETCHED = 3'b010} state_t;
   state_t                             r_state;
   logic                               r_mem_read_valid;
   logic [PROGRAM_MEM_ADDR_BITS-1:0]   r_mem_read_address;
   logic [PROGRAM_MEM_DATA_BITS-1:0]   r_instruction;
   logic [15:0]                        r_hit_count;
   logic [15:0]                        r_miss_count;
   logic [CACHE_LINES-1:0]             r_valid;
   logic [TW-1:0]                      r_tag [CACHE_LINES];
   logic [PROGRAM_MEM_DATA_BITS-1:0]   r_data [CACHE_LINES];
   logic [IW-1:0]                      w_idx;
   logic [TW-1:0]                      w_tag;
   logic [IW-1:0]                      w_fidx;
   logic [TW-1:0]                      w_ftag;
   logic                               w_hit;
   logic                               w_fill;
   assign w_idx  = current_pc[IW-1:0];
   assign w_tag  = current_pc[PROGRAM_MEM_ADDR_BITS-1:IW];
   // fills are placed by the registered request address, not the live pc
   assign w_fidx = r_mem_read_address[IW-1:0];
   assign w_ftag = r_mem_read_address[PROGRAM_MEM_ADDR_BITS-1:IW];
   assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_fill = (r_state == S_FETCHING) && mem_read_ready;
   assign mem_read_valid   = r_mem_read_valid;
   assign mem_read_address = r_mem_read_address;
   assign fetcher_state    = r_state;
   assign instruction      = r_instruction;
   assign hit_count        = r_hit_count;
   assign miss_count       = r_miss_count;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state            <= S_IDLE;
         r_mem_read_valid   <= 1'b0;
         r_mem_read_address <= '0;
         r_instruction      <= '0;
         r_hit_count        <= '0;
         r_miss_count       <= '0;
         r_valid            <= '0;
      end else begin
         case (r_state)
            S_IDLE:
               if (core_state == C_FETCH) begin
                  if (w_hit) begin
                     r_instruction <= r_data[w_idx];
                     r_hit_count   <= r_hit_count + 16'(r_hit_count != 16'hFFFF);
                     r_state       <= S_FETCHED;
                  end else begin
                     r_mem_read_valid   <= 1'b1;
                     r_mem_read_address <= current_pc;
                     r_miss_count       <= r_miss_count + 16'(r_miss_count != 16'hFFFF);
                     r_state            <= S_FETCHING;
                  end
               end
            S_FETCHING:
               if (mem_read_ready) begin
                  r_mem_read_valid <= 1'b0;
                  r_instruction    <= mem_read_data;
                  r_valid[w_fidx]  <= 1'b1;
                  r_state          <= S_FETCHED;
               end
            S_FETCHED:
               if (core_state == C_DECODE) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
         // placed last so a coincident fill still ends with its line invalid
         if (invalidate) r_valid <= '0;
      end
   end
   always_ff @(posedge clk) begin
      if (w_fill && !reset) begin
         r_tag[w_fidx]  <= w_ftag;
         r_data[w_fidx] <= mem_read_data;
      end
   end
endmodule

// File: tb/tb_fetcher_icache.sv
// tb_fetcher_icache: directed and randomized checks of fetcher_icache against a line-array model.
module tb_fetcher_icache;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  core_state = 3'b000;
   logic [7:0]  current_pc = '0;
   logic        invalidate = 1'b0;
   logic        mem_read_valid;
   logic [7:0]  mem_read_address;
   logic        mem_read_ready = 1'b0;
   logic [15:0] mem_read_data = '0;
   logic [2:0]  fetcher_state;
   logic [15:0] instruction;
   logic [15:0] hit_count;
   logic [15:0] miss_count;
   int errors = 0;
   int checks = 0;
   bit m_valid [4];
   int m_tag [4];
   int m_data [4];
   int m_hits = 0;
   int m_misses = 0;
   int m_instr = 0;
   fetcher_icache #(.PROGRAM_MEM_ADDR_BITS(8), .PROGRAM_MEM_DATA_BITS(16), .CACHE_LINES(4)) dut (
      .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
      .invalidate(invalidate), .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
      .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data), .fetcher_state(fetcher_state),
      .instruction(instruction), .hit_count(hit_count), .miss_count(miss_count)
   );
   always #5 clk = ~clk;
   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic clear_model();
      for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      core_state = 3'b000;
      tick();
      reset = 1'b0;
      clear_model();
      m_hits = 0;
      m_misses = 0;
      m_instr = 0;
   endtask
   task automatic check_counts(input string tag);
      chk({tag, "_hits"}, hit_count, sat(m_hits));
      chk({tag, "_misses"}, miss_count, sat(m_misses));
   endtask
   // one complete fetch: lookup, optional memory fill after lat cycles, hold, then DECODE
   task automatic do_fetch(input logic [7:0] pc, input int lat, input logic [15:0] d,
                           input bit inv_lookup, input bit inv_fill);
      int idx;
      bit hit;
      idx = pc % 4;
      hit = m_valid[idx] && (m_tag[idx] == pc / 4);
      core_state = 3'b001;
      current_pc = pc;
      invalidate = inv_lookup;
      tick();
      invalidate = 1'b0;
      if (inv_lookup) clear_model();
      if (hit) begin
         m_hits++;
         m_instr = m_data[idx];
         chk("hit_state", fetcher_state, 3'b010);
         chk("hit_instr", instruction, m_instr);
         chk("hit_noreq", mem_read_valid, 1'b0);
         check_counts("hit");
      end else begin
         m_misses++;
         chk("miss_state", fetcher_state, 3'b001);
         chk("miss_req", mem_read_valid, 1'b1);
         chk("miss_addr", mem_read_address, pc);
         check_counts("miss");
         current_pc = pc ^ 8'hFF;
         for (int i = 1; i < lat; i++) begin
            tick();
            chk("wait_state", fetcher_state, 3'b001);
            chk("wait_req", mem_read_valid, 1'b1);
            chk("wait_addr", mem_read_address, pc);
         end
         mem_read_ready = 1'b1;
         mem_read_data = d;
         invalidate = inv_fill;
         tick();
         mem_read_ready = 1'b0;
         invalidate = 1'b0;
         mem_read_data = 16'($urandom);
         m_data[idx] = d;
         m_tag[idx] = pc / 4;
         m_valid[idx] = 1'b1;
         if (inv_fill) clear_model();
         m_instr = d;
         chk("fill_state", fetcher_state, 3'b010);
         chk("fill_instr", instruction, m_instr);
         chk("fill_req", mem_read_valid, 1'b0);
      end
      current_pc = pc;
      tick();
      chk("hold_state", fetcher_state, 3'b010);
      chk("hold_req", mem_read_valid, 1'b0);
      check_counts("hold");
      core_state = 3'b010;
      tick();
      chk("decode_state", fetcher_state, 3'b000);
      chk("decode_instr", instruction, m_instr);
      core_state = 3'b000;
   endtask
   task automatic idle_noise();
      logic [2:0] s;
      s = 3'($urandom_range(0, 7));
      if (s == 3'b001) s = 3'b110;
      core_state = s;
      current_pc = 8'($urandom);
      mem_read_ready = 1'($urandom);
      tick();
      mem_read_ready = 1'b0;
      core_state = 3'b000;
      chk("noise_state", fetcher_state, 3'b000);
      chk("noise_req", mem_read_valid, 1'b0);
      check_counts("noise");
   endtask
   initial begin
      do_reset();
      chk("rst_state", fetcher_state, 3'b000);
      chk("rst_req", mem_read_valid, 1'b0);
      chk("rst_addr", mem_read_address, 8'h00);
      chk("rst_instr", instruction, 16'h0000);
      check_counts("rst");
      do_fetch(8'h05, 3, 16'h3123, 1'b0, 1'b0);
      do_fetch(8'h05, 1, 16'h0000, 1'b0, 1'b0);
      do_fetch(8'h09, 2, 16'h9A07, 1'b0, 1'b0);
      do_fetch(8'h05, 1, 16'h3123, 1'b0, 1'b0);
      chk("conflict_misses", miss_count, 16'd3);
      do_fetch(8'h02, 2, 16'h0202, 1'b0, 1'b0);
      invalidate = 1'b1;
      tick();
      invalidate = 1'b0;
      clear_model();
      do_fetch(8'h02, 1, 16'h0222, 1'b0, 1'b0);
      do_fetch(8'h03, 2, 16'h0303, 1'b0, 1'b1);
      do_fetch(8'h03, 1, 16'h0333, 1'b0, 1'b0);
      do_fetch(8'h03, 1, 16'h0000, 1'b1, 1'b0);
      do_fetch(8'h03, 1, 16'h0345, 1'b0, 1'b0);
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) idle_noise();
         do_fetch(8'($urandom_range(0, 15)), $urandom_range(1, 4), 16'($urandom),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
      end
      do_reset();
      core_state = 3'b001;
      current_pc = 8'h10;
      tick();
      chk("midrst_fetching", fetcher_state, 3'b001);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      core_state = 3'b000;
      mem_read_ready = 1'b1;
      mem_read_data = 16'hBEEF;
      tick();
      mem_read_ready = 1'b0;
      chk("midrst_state", fetcher_state, 3'b000);
      chk("midrst_req", mem_read_valid, 1'b0);
      chk("midrst_instr", instruction, 16'h0000);
      check_counts("midrst");
      do_fetch(8'h10, 1, 16'h1010, 1'b0, 1'b0);
      do_reset();
      do_fetch(8'h01, 2, 16'h0101, 1'b0, 1'b0);
      for (int i = 0; i < 200; i++) do_fetch(8'h01, 1, 16'h0000, 1'b0, 1'b0);
      force dut.r_hit_count = 16'hFFFD;
      #1;
      release dut.r_hit_count;
      m_hits = 65533;
      for (int i = 0; i < 4; i++) do_fetch(8'h01, 1, 16'h0000, 1'b0, 1'b0);
      chk("sat_hits", hit_count, 16'hFFFF);
      chk("sat_misses", miss_count, 16'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
